mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Request-side initiator for the line-granular main-memory port. Arbitrates icache and dcache miss
//  requests (plus dcache dirty writeback) onto the single req_*/rec_* memory interface.
//  Models fixed memory latency and routes the returned cacheline to the granted cache.
//  Sits between the caches and the memory responder. One transaction in flight.
// PARAMETERS
//  MEM_LATENCY  5  wait cycles inserted between grant and issue to memory (0 legal)
// PORTS
//  clk                 in   1      clock; single clock domain
//  rst                 in   1      synchronous, active-high reset
//  ic_req              in   1      icache miss; held high until ic_fill_en
//  ic_addr             in   pptr_t icache fill address
//  ic_fill_en          out  1      one-cycle fill strobe to icache
//  ic_fill_line        out  cacheline_t  fill data, valid with ic_fill_en
//  dc_req              in   1      dcache miss; held high until dc_fill_en
//  dc_addr             in   pptr_t dcache fill address
//  dc_wb               in   1      eviction dirty; qualified by dc_req
//  dc_wb_addr          in   pptr_t victim line address
//  dc_wb_line          in   cacheline_t  victim data
//  dc_fill_en          out  1      one-cycle fill strobe to dcache
//  dc_fill_line        out  cacheline_t  fill data, valid with dc_fill_en
//  mem_req_ren         out  1      read request to memory
//  mem_req_raddr       out  pptr_t read address
//  mem_req_wen         out  1      write request to memory
//  mem_req_waddr       out  pptr_t write address
//  mem_req_wcacheline  out  cacheline_t  write data
//  mem_rec_en          in   1      memory response valid (1 cycle after mem_req_ren)
//  mem_rec_addr        in   pptr_t response address
//  mem_rec_cacheline   in   cacheline_t  response data
// BEHAVIOUR
//  - All outputs registered; on rst every output = 0, state = IDLE, cnt = 0, RR pointer = icache.
//  - FSM: IDLE -> WAIT -> ISSUE -> RESP -> DELIVER -> IDLE.
//  - IDLE: if any req, grant per arbitration. Latch owner, fill addr, wb flag/addr/line.
//    Go to WAIT with cnt = MEM_LATENCY, or straight to ISSUE if MEM_LATENCY == 0.
//  - WAIT: cnt decrements each cycle; cnt == 1 -> ISSUE.
//  - ISSUE (1 cycle): mem_req_ren = 1, raddr = latched fill addr. If latched wb: mem_req_wen = 1
//    same cycle with wb addr/line. Next state RESP.
//  - RESP: wait for mem_rec_en && mem_rec_addr == latched addr; capture line -> DELIVER.
//    Mismatched rec_addr: ignored, stay in RESP; sim assertion fires. rec_en outside RESP: ignored.
//  - DELIVER (1 cycle): owner's *_fill_en = 1, *_fill_line = captured line; other fill_en = 0.
//    Next state IDLE.
//  - Client contract: cache clears req on the edge ending its fill_en cycle. IDLE therefore never
//    re-grants a serviced request.
//  - Latency: req first high in cycle 0 (state IDLE) -> fill_en high in cycle MEM_LATENCY+3.
//  - Requests arriving while not IDLE are held by the client and are not lost.
//  - dc_wb_addr must differ from dc_addr in tag/idx; a same-line wb+read returns stale data.
//    A sim assertion flags this case.
//  - cnt width = $clog2(MEM_LATENCY+1), min 1. Decrement never underflows.
//  - rst mid-transaction: abort, return to IDLE, drop latched request. No mem_req_* after rst edge.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin. On a simultaneous request, grant the client not served last.
//    Pointer updates at each grant.
//  MEM_ARB_RR_EN undefined: fixed priority, dcache beats icache. No pointer state.
// STRUCTURE
//  - Add to common package: arb_state_t enum (IDLE, WAIT, ISSUE, RESP, DELIVER);
//    arb_client_t enum (CLIENT_IC, CLIENT_DC); MEM_LATENCY default constant.
//  - pptr_t and cacheline_t are reused from the common package.
//  - One sub-module: mem_arb_pick. Combinational grant from ic_req/dc_req/last-owner;
//    holds the RR pointer flop when MEM_ARB_RR_EN is defined.
// TESTING
//  1. rst held 2 cycles -> all outputs 0. Release, no req -> mem_req_ren stays 0 for 20 cycles.
//  2. MEM_LATENCY=5, ic_req addr 0x00040 cycle 0 -> mem_req_ren cycle 6 (raddr 0x00040);
//     ic_fill_en cycle 8 with responder data. dc_fill_en stays 0.
//  3. dc_req addr 0x01000 + dc_wb addr 0x02000 line 0xA5.. -> ISSUE cycle has ren and wen together,
//     waddr 0x02000. dc_fill_en returns line at 0x01000.
//  4. ic_req and dc_req both in cycle 0, held:
//     - fixed priority: dcache filled at cycle L+3, icache at cycle 2L+7.
//     - MEM_ARB_RR_EN: second simultaneous round alternates owner.
//  5. MEM_LATENCY=0 -> fill_en at cycle 3. Back-to-back ic_req reasserted cycle 4 -> next fill cycle 7.
//  6. rst asserted during WAIT -> IDLE next cycle, no mem_req_ren, no fill_en. Fresh req then
//     served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared types for the memory-port arbiter: physical pointer and cacheline
//   types, the arbiter FSM state and client enums, the default memory latency,
//   and a helper that strips the byte offset from an address.
package mem_arbiter_pkg;

   localparam int unsigned PPTR_W              = 32;
   localparam int unsigned LINE_W              = 256;
   localparam int unsigned LINE_OFFSET_W       = $clog2(LINE_W / 8);
   localparam int unsigned MEM_LATENCY_DEFAULT = 5;

   typedef logic [PPTR_W-1:0] pptr_t;
   typedef logic [LINE_W-1:0] cacheline_t;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      ISSUE,
      RESP,
      DELIVER
   } arb_state_t;

   typedef enum logic {
      CLIENT_IC,
      CLIENT_DC
   } arb_client_t;

   // Tag + index portion of an address; two addresses with equal results
   // name the same cacheline.
   function automatic logic [PPTR_W-LINE_OFFSET_W-1:0] line_index(input pptr_t addr);
      return addr[PPTR_W-1:LINE_OFFSET_W];
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Combinational grant selection between the icache and dcache miss requests.
//   Build option MEM_ARB_RR_EN:
//     defined   - round-robin: on a simultaneous request the client not served
//                 last wins; the last-served pointer updates on every grant.
//     undefined - fixed priority, dcache beats icache; no state.
// Ports
//   clk, rst      clock / synchronous active-high reset (round-robin build only)
//   grant_take    arbiter is consuming the grant this cycle (round-robin build only)
//   ic_req        icache request
//   dc_req        dcache request
//   grant_valid   at least one request pending
//   grant_client  selected client
module mem_arb_pick
   import mem_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
   input  logic        clk,
   input  logic        rst,
   input  logic        grant_take,
`endif
   input  logic        ic_req,
   input  logic        dc_req,
   output logic        grant_valid,
   output arb_client_t grant_client
);

   assign grant_valid = ic_req | dc_req;

`ifdef MEM_ARB_RR_EN
   arb_client_t last_q;
   arb_client_t last_d;

   always_comb begin
      grant_client = CLIENT_IC;
      last_d       = last_q;
      if (ic_req && dc_req) begin
         grant_client = (last_q == CLIENT_IC) ? CLIENT_DC : CLIENT_IC;
      end else if (dc_req) begin
         grant_client = CLIENT_DC;
      end
      if (grant_take) begin
         last_d = grant_client;
      end
   end

   // Reset value "icache served last" makes the first contested grant go to dcache.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= CLIENT_IC;
      end else begin
         last_q <= last_d;
      end
   end
`else
   always_comb begin
      grant_client = CLIENT_IC;
      if (dc_req) begin
         grant_client = CLIENT_DC;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Request-side initiator for the line-granular main-memory port. Arbitrates
//   icache and dcache misses (with optional dcache dirty writeback) onto the
//   single mem_req_*/mem_rec_* interface, inserts a fixed wait of MEM_LATENCY
//   cycles before issuing, and routes the returned line to the granted cache.
//   One transaction in flight. All outputs are registered.
//   Build option MEM_ARB_RR_EN selects round-robin arbitration (see mem_arb_pick);
//   default build is fixed priority, dcache first.
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   ic_req/ic_addr                 icache miss request and fill address
//   ic_fill_en/ic_fill_line        one-cycle fill strobe and data to icache
//   dc_req/dc_addr                 dcache miss request and fill address
//   dc_wb/dc_wb_addr/dc_wb_line    dirty victim writeback (qualified by dc_req)
//   dc_fill_en/dc_fill_line        one-cycle fill strobe and data to dcache
//   mem_req_ren/mem_req_raddr      memory read request
//   mem_req_wen/mem_req_waddr/
//   mem_req_wcacheline             memory write request
//   mem_rec_en/mem_rec_addr/
//   mem_rec_cacheline              memory response
//
// state   | meaning
// IDLE    | no transaction; grant a pending request and latch it
// WAIT    | down-counting modelled memory latency
// ISSUE   | read (and optional writeback) presented to memory for one cycle
// RESP    | waiting for a response whose address matches the latched fill address
// DELIVER | fill strobe to the owning cache for one cycle
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ic_req,
   input  pptr_t      ic_addr,
   output logic       ic_fill_en,
   output cacheline_t ic_fill_line,
   input  logic       dc_req,
   input  pptr_t      dc_addr,
   input  logic       dc_wb,
   input  pptr_t      dc_wb_addr,
   input  cacheline_t dc_wb_line,
   output logic       dc_fill_en,
   output cacheline_t dc_fill_line,
   output logic       mem_req_ren,
   output pptr_t      mem_req_raddr,
   output logic       mem_req_wen,
   output pptr_t      mem_req_waddr,
   output cacheline_t mem_req_wcacheline,
   input  logic       mem_rec_en,
   input  pptr_t      mem_rec_addr,
   input  cacheline_t mem_rec_cacheline
);

   localparam int unsigned CNT_W = (MEM_LATENCY == 0) ? 1 : $clog2(MEM_LATENCY + 1);

   arb_state_t  state_q,   state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   arb_client_t owner_q,   owner_d;
   pptr_t       addr_q,    addr_d;
   logic        wb_q,      wb_d;
   pptr_t       wb_addr_q, wb_addr_d;
   cacheline_t  wb_line_q, wb_line_d;

   logic        ic_fill_en_q,   ic_fill_en_d;
   cacheline_t  ic_fill_line_q, ic_fill_line_d;
   logic        dc_fill_en_q,   dc_fill_en_d;
   cacheline_t  dc_fill_line_q, dc_fill_line_d;
   logic        ren_q,   ren_d;
   pptr_t       raddr_q, raddr_d;
   logic        wen_q,   wen_d;
   pptr_t       waddr_q, waddr_d;
   cacheline_t  wline_q, wline_d;

   logic        grant_valid;
   arb_client_t grant_client;

`ifdef MEM_ARB_RR_EN
   logic grant_take;
   assign grant_take = (state_q == IDLE) && grant_valid;

   mem_arb_pick u_pick (
      .clk          (clk),
      .rst          (rst),
      .grant_take   (grant_take),
      .ic_req       (ic_req),
      .dc_req       (dc_req),
      .grant_valid  (grant_valid),
      .grant_client (grant_client)
   );
`else
   mem_arb_pick u_pick (
      .ic_req       (ic_req),
      .dc_req       (dc_req),
      .grant_valid  (grant_valid),
      .grant_client (grant_client)
   );
`endif

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      owner_d        = owner_q;
      addr_d         = addr_q;
      wb_d           = wb_q;
      wb_addr_d      = wb_addr_q;
      wb_line_d      = wb_line_q;
      ic_fill_en_d   = 1'b0;
      ic_fill_line_d = '0;
      dc_fill_en_d   = 1'b0;
      dc_fill_line_d = '0;
      ren_d          = 1'b0;
      raddr_d        = '0;
      wen_d          = 1'b0;
      waddr_d        = '0;
      wline_d        = '0;

      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               owner_d = grant_client;
               if (grant_client == CLIENT_DC) begin
                  addr_d    = dc_addr;
                  wb_d      = dc_wb;
                  wb_addr_d = dc_wb_addr;
                  wb_line_d = dc_wb_line;
               end else begin
                  addr_d    = ic_addr;
                  wb_d      = 1'b0;
                  wb_addr_d = '0;
                  wb_line_d = '0;
               end
               if (MEM_LATENCY == 0) begin
                  state_d = ISSUE;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(MEM_LATENCY);
               end
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end
            // <= rather than == so a corrupted zero count cannot lock the FSM
            if (cnt_q <= CNT_W'(1)) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = RESP;
         end
         RESP: begin
            if (mem_rec_en && (mem_rec_addr == addr_q)) begin
               state_d = DELIVER;
               if (owner_q == CLIENT_DC) begin
                  dc_fill_en_d   = 1'b1;
                  dc_fill_line_d = mem_rec_cacheline;
               end else begin
                  ic_fill_en_d   = 1'b1;
                  ic_fill_line_d = mem_rec_cacheline;
               end
            end
         end
         DELIVER: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // ISSUE is always left after one cycle, so this fires only on entry and
      // the registered request lines are high exactly during ISSUE.
      if (state_d == ISSUE) begin
         ren_d   = 1'b1;
         raddr_d = addr_d;
         if (wb_d) begin
            wen_d   = 1'b1;
            waddr_d = wb_addr_d;
            wline_d = wb_line_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         owner_q        <= CLIENT_IC;
         addr_q         <= '0;
         wb_q           <= 1'b0;
         wb_addr_q      <= '0;
         wb_line_q      <= '0;
         ic_fill_en_q   <= 1'b0;
         ic_fill_line_q <= '0;
         dc_fill_en_q   <= 1'b0;
         dc_fill_line_q <= '0;
         ren_q          <= 1'b0;
         raddr_q        <= '0;
         wen_q          <= 1'b0;
         waddr_q        <= '0;
         wline_q        <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         owner_q        <= owner_d;
         addr_q         <= addr_d;
         wb_q           <= wb_d;
         wb_addr_q      <= wb_addr_d;
         wb_line_q      <= wb_line_d;
         ic_fill_en_q   <= ic_fill_en_d;
         ic_fill_line_q <= ic_fill_line_d;
         dc_fill_en_q   <= dc_fill_en_d;
         dc_fill_line_q <= dc_fill_line_d;
         ren_q          <= ren_d;
         raddr_q        <= raddr_d;
         wen_q          <= wen_d;
         waddr_q        <= waddr_d;
         wline_q        <= wline_d;
      end
   end

   assign ic_fill_en         = ic_fill_en_q;
   assign ic_fill_line       = ic_fill_line_q;
   assign dc_fill_en         = dc_fill_en_q;
   assign dc_fill_line       = dc_fill_line_q;
   assign mem_req_ren        = ren_q;
   assign mem_req_raddr      = raddr_q;
   assign mem_req_wen        = wen_q;
   assign mem_req_waddr      = waddr_q;
   assign mem_req_wcacheline = wline_q;

   // A response for some other line is dropped; flag it, since the fill then stalls.
   a_rec_addr_match: assert property (@(posedge clk) disable iff (rst)
      (state_q == RESP && mem_rec_en) |-> (mem_rec_addr == addr_q));

   // Writeback and fill of the same line in one transaction would return stale data.
   a_wb_distinct_line: assert property (@(posedge clk) disable iff (rst)
      (state_q == IDLE && grant_valid && grant_client == CLIENT_DC && dc_wb)
      |-> (line_index(dc_wb_addr) != line_index(dc_addr)));

endmodule
